// File: rtl/sdram_pll_seq_pkg.sv
// Shared types for the SDRAM PLL reset sequencer.
// Contents: state width and the FSM state enum. The encodings are also the
// debug codes driven on state_o.
package sdram_pll_seq_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } state_t;

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer that brings the asynchronous PLL lock into refclk.
// Ports:
//   clk  - destination clock
//   rst  - synchronous active-high reset; both flops clear to 0
//   d    - asynchronous input
//   q    - synchronized output, two edges behind d
module pll_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sdram_pll_reset_sequencer.sv
// Sequences the SDRAM PLL: pulses its reset, waits for lock with timeout and
// retry, qualifies lock stability, then releases the SDRAM-domain reset.
// Re-sequences on lock loss or on a force_relock request.
// Ports:
//   refclk       - reference clock, the only clock
//   rst          - synchronous active-high reset
//   pll_locked   - PLL lock, asynchronous to refclk
//   force_relock - single-cycle request to restart the sequence
//   pll_rst      - reset to the PLL
//   sys_rst      - active-high reset to SDRAM-side logic
//   ready        - clocks valid and sys_rst released
//   fail         - lock retries exhausted
//   retry_cnt    - failed lock attempts in the current episode
//   state_o      - current FSM state code
module sdram_pll_reset_sequencer
  import sdram_pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 50000,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned RELEASE_DELAY  = 8,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned RETRY_W        = 2
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               force_relock,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   RELEASE_LAST = CNT_W'(RELEASE_DELAY - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt, cnt_inc;
  logic [RETRY_W-1:0] retry_nxt, retry_inc;
  logic               pll_rst_nxt, sys_rst_nxt, ready_nxt, fail_nxt;
  logic               lock_s;

  pll_lock_sync u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  // Saturating increment: the shared counter never wraps.
  assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign retry_inc = retry_cnt + RETRY_W'(1);
  assign state_o   = state_q;

  // State, counter and output registers.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= ST_PLL_RST;
      cnt_q     <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      retry_cnt <= retry_nxt;
      pll_rst   <= pll_rst_nxt;
      sys_rst   <= sys_rst_nxt;
      ready     <= ready_nxt;
      fail      <= fail_nxt;
    end
  end

  // Next state, counter and retry count; outputs decode the next state so
  // they change on the same edge as the state.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_inc;
    retry_nxt = retry_cnt;

    if (force_relock) begin
      state_nxt = ST_PLL_RST;
      cnt_nxt   = '0;
      retry_nxt = '0;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_nxt = ST_WAIT_LOCK;
            cnt_nxt   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt = ST_STABLE;
            cnt_nxt   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            retry_nxt = retry_inc;
            cnt_nxt   = '0;
            state_nxt = (retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_PLL_RST;
          end
        end
        ST_STABLE: begin
          // A glitch in lock restarts the lock wait but is not a failed attempt.
          if (!lock_s) begin
            state_nxt = ST_WAIT_LOCK;
            cnt_nxt   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_nxt = ST_RELEASE;
            cnt_nxt   = '0;
          end
        end
        ST_RELEASE: begin
          if (!lock_s) begin
            state_nxt = ST_WAIT_LOCK;
            cnt_nxt   = '0;
          end else if (cnt_q == RELEASE_LAST) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
            retry_nxt = '0;
          end
        end
        ST_RUN: begin
          retry_nxt = '0;
          if (!lock_s) begin
            state_nxt = ST_PLL_RST;
            cnt_nxt   = '0;
          end
        end
        ST_FAIL: begin
          state_nxt = ST_FAIL;
        end
        default: begin
          state_nxt = ST_PLL_RST;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end
      endcase
    end

    pll_rst_nxt = 1'b0;
    sys_rst_nxt = 1'b1;
    ready_nxt   = 1'b0;
    fail_nxt    = 1'b0;
    case (state_nxt)
      ST_PLL_RST: pll_rst_nxt = 1'b1;
      ST_RUN: begin
        sys_rst_nxt = 1'b0;
        ready_nxt   = 1'b1;
      end
      ST_FAIL: begin
        pll_rst_nxt = 1'b1;
        fail_nxt    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_pll_reset_sequencer.sv
// Directed self-checking bench for sdram_pll_reset_sequencer with shortened
// timing parameters. Inputs change and outputs are sampled 1 ns after each
// rising edge.
module tb_sdram_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       force_relock = 1'b0;
  logic       pll_rst, sys_rst, ready, fail;
  logic [1:0] retry_cnt;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  sdram_pll_reset_sequencer #(
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (20),
    .STABLE_CYCLES  (8),
    .RELEASE_DELAY  (3),
    .MAX_RETRIES    (2),
    .CNT_W          (16),
    .RETRY_W        (2)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .force_relock (force_relock),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .fail         (fail),
    .retry_cnt    (retry_cnt),
    .state_o      (state_o)
  );

  always #5 refclk = ~refclk;

  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  // Leaves the bench 1 ns after the reset edge, with rst already low.
  task automatic reset_dut();
    rst = 1'b1;
    pll_locked = 1'b0;
    force_relock = 1'b0;
    step(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if ({state_o, pll_rst, sys_rst, ready, fail, retry_cnt} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset: got st=%0d prst=%b srst=%b rdy=%b fail=%b rc=%0d exp st=0 prst=1 srst=1 rdy=0 fail=0 rc=0",
               state_o, pll_rst, sys_rst, ready, fail, retry_cnt);
    end
  endtask

  task automatic test_nominal();
    reset_dut();
    step(3);
    checks++;
    if (pll_rst !== 1'b1 || state_o !== 3'd0) begin
      errors++;
      $display("FAIL nom_pllrst_held: got prst=%b st=%0d exp prst=1 st=0", pll_rst, state_o);
    end
    step(1);
    checks++;
    if (pll_rst !== 1'b0 || state_o !== 3'd1) begin
      errors++;
      $display("FAIL nom_wait_lock: got prst=%b st=%0d exp prst=0 st=1", pll_rst, state_o);
    end
    step(5);
    pll_locked = 1'b1;
    step(2);
    checks++;
    if (state_o !== 3'd1) begin
      errors++;
      $display("FAIL nom_sync_latency: got st=%0d exp 1", state_o);
    end
    step(1);
    checks++;
    if (state_o !== 3'd2) begin
      errors++;
      $display("FAIL nom_stable: got st=%0d exp 2", state_o);
    end
    step(10);
    checks++;
    if (state_o !== 3'd3 || sys_rst !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL nom_release: got st=%0d srst=%b rdy=%b exp st=3 srst=1 rdy=0", state_o, sys_rst, ready);
    end
    step(1);
    checks++;
    if (state_o !== 3'd4 || sys_rst !== 1'b0 || ready !== 1'b1 || retry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL nom_run: got st=%0d srst=%b rdy=%b rc=%0d exp st=4 srst=0 rdy=1 rc=0",
               state_o, sys_rst, ready, retry_cnt);
    end
  endtask

  // Reset, then lock 1 cycle into WAIT_LOCK; RUN is reached 14 edges later.
  task automatic go_run();
    reset_dut();
    step(4);
    pll_locked = 1'b1;
    step(14);
  endtask

  task automatic test_lock_loss_run();
    go_run();
    pll_locked = 1'b0;
    step(2);
    checks++;
    if (ready !== 1'b1 || sys_rst !== 1'b0) begin
      errors++;
      $display("FAIL loss_still_run: got rdy=%b srst=%b exp rdy=1 srst=0", ready, sys_rst);
    end
    step(1);
    checks++;
    if (sys_rst !== 1'b1 || ready !== 1'b0 || pll_rst !== 1'b1 || state_o !== 3'd0) begin
      errors++;
      $display("FAIL loss_reseq: got srst=%b rdy=%b prst=%b st=%0d exp srst=1 rdy=0 prst=1 st=0",
               sys_rst, ready, pll_rst, state_o);
    end
    step(3);
    checks++;
    if (pll_rst !== 1'b1) begin
      errors++;
      $display("FAIL loss_pllrst_len: got prst=%b exp 1", pll_rst);
    end
    step(1);
    checks++;
    if (pll_rst !== 1'b0 || retry_cnt !== 2'd0 || state_o !== 3'd1) begin
      errors++;
      $display("FAIL loss_wait: got prst=%b rc=%0d st=%0d exp prst=0 rc=0 st=1", pll_rst, retry_cnt, state_o);
    end
  endtask

  task automatic test_timeout_fail();
    reset_dut();
    step(23);
    checks++;
    if (retry_cnt !== 2'd0 || state_o !== 3'd1) begin
      errors++;
      $display("FAIL to_before_first: got rc=%0d st=%0d exp rc=0 st=1", retry_cnt, state_o);
    end
    step(1);
    checks++;
    if (retry_cnt !== 2'd1 || state_o !== 3'd0 || pll_rst !== 1'b1) begin
      errors++;
      $display("FAIL to_first: got rc=%0d st=%0d prst=%b exp rc=1 st=0 prst=1", retry_cnt, state_o, pll_rst);
    end
    step(23);
    checks++;
    if (fail !== 1'b0 || state_o !== 3'd1) begin
      errors++;
      $display("FAIL to_before_fail: got fail=%b st=%0d exp fail=0 st=1", fail, state_o);
    end
    step(1);
    checks++;
    if (fail !== 1'b1 || pll_rst !== 1'b1 || sys_rst !== 1'b1 || retry_cnt !== 2'd2 || state_o !== 3'd5) begin
      errors++;
      $display("FAIL to_fail: got fail=%b prst=%b srst=%b rc=%0d st=%0d exp fail=1 prst=1 srst=1 rc=2 st=5",
               fail, pll_rst, sys_rst, retry_cnt, state_o);
    end
  endtask

  task automatic test_stable_glitch();
    reset_dut();
    step(4);
    pll_locked = 1'b1;
    step(7);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(2);
    checks++;
    if (state_o !== 3'd1 || sys_rst !== 1'b1 || retry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL glitch_back_wait: got st=%0d srst=%b rc=%0d exp st=1 srst=1 rc=0", state_o, sys_rst, retry_cnt);
    end
    step(11);
    checks++;
    if (sys_rst !== 1'b1 || state_o !== 3'd3) begin
      errors++;
      $display("FAIL glitch_pre_release: got srst=%b st=%0d exp srst=1 st=3", sys_rst, state_o);
    end
    step(1);
    checks++;
    if (sys_rst !== 1'b0 || ready !== 1'b1 || retry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL glitch_release: got srst=%b rdy=%b rc=%0d exp srst=0 rdy=1 rc=0", sys_rst, ready, retry_cnt);
    end
  endtask

  task automatic test_force_relock();
    go_run();
    force_relock = 1'b1;
    step(1);
    force_relock = 1'b0;
    checks++;
    if (state_o !== 3'd0 || pll_rst !== 1'b1 || sys_rst !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL force_run: got st=%0d prst=%b srst=%b rdy=%b exp st=0 prst=1 srst=1 rdy=0",
               state_o, pll_rst, sys_rst, ready);
    end
    step(16);
    checks++;
    if (ready !== 1'b1 || state_o !== 3'd4) begin
      errors++;
      $display("FAIL force_run_reseq: got rdy=%b st=%0d exp rdy=1 st=4", ready, state_o);
    end

    reset_dut();
    step(48);
    pll_locked = 1'b1;
    step(3);
    checks++;
    if (state_o !== 3'd5 || fail !== 1'b1 || retry_cnt !== 2'd2) begin
      errors++;
      $display("FAIL fail_sticky: got st=%0d fail=%b rc=%0d exp st=5 fail=1 rc=2", state_o, fail, retry_cnt);
    end
    force_relock = 1'b1;
    step(1);
    force_relock = 1'b0;
    checks++;
    if (state_o !== 3'd0 || fail !== 1'b0 || retry_cnt !== 2'd0 || pll_rst !== 1'b1) begin
      errors++;
      $display("FAIL force_fail: got st=%0d fail=%b rc=%0d prst=%b exp st=0 fail=0 rc=0 prst=1",
               state_o, fail, retry_cnt, pll_rst);
    end
    step(15);
    checks++;
    if (sys_rst !== 1'b1 || state_o !== 3'd3) begin
      errors++;
      $display("FAIL force_fail_pre: got srst=%b st=%0d exp srst=1 st=3", sys_rst, state_o);
    end
    step(1);
    checks++;
    if (ready !== 1'b1 || sys_rst !== 1'b0 || retry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL force_fail_run: got rdy=%b srst=%b rc=%0d exp rdy=1 srst=0 rc=0", ready, sys_rst, retry_cnt);
    end
  endtask

  task automatic test_rst_midway();
    reset_dut();
    step(4);
    pll_locked = 1'b1;
    step(4);
    checks++;
    if (state_o !== 3'd2) begin
      errors++;
      $display("FAIL rst_setup_stable: got st=%0d exp 2", state_o);
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++;
    if ({state_o, pll_rst, sys_rst, ready, fail, retry_cnt} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL rst_in_stable: got st=%0d prst=%b srst=%b rdy=%b fail=%b rc=%0d exp st=0 prst=1 srst=1 rdy=0 fail=0 rc=0",
               state_o, pll_rst, sys_rst, ready, fail, retry_cnt);
    end
    go_run();
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_setup_run: got rdy=%b exp 1", ready);
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++;
    if ({state_o, pll_rst, sys_rst, ready, fail, retry_cnt} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL rst_in_run: got st=%0d prst=%b srst=%b rdy=%b fail=%b rc=%0d exp st=0 prst=1 srst=1 rdy=0 fail=0 rc=0",
               state_o, pll_rst, sys_rst, ready, fail, retry_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout_fail();
    test_stable_glitch();
    test_lock_loss_run();
    test_force_relock();
    test_rst_midway();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
